// File: rtl/pulse_pkg.sv
// Shared state encoding and default cooldown length for the pulse scheduler.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int GAP_CYC_DEFAULT = 2;

endpackage

// File: rtl/pulse_sched_if.sv
// Request/length inputs and pulse/grant/status outputs of the pulse scheduler.
interface pulse_sched_if #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
);

    logic [N_REQ-1:0] REQ_IN;
    logic [LEN_W-1:0] LEN_IN;
    logic             Y_OUT;
    logic [N_REQ-1:0] GNT_OUT;
    logic             BUSY_OUT;
    logic             DONE_OUT;

    modport master (
        output REQ_IN, LEN_IN,
        input  Y_OUT, GNT_OUT, BUSY_OUT, DONE_OUT
    );

    modport slave (
        input  REQ_IN, LEN_IN,
        output Y_OUT, GNT_OUT, BUSY_OUT, DONE_OUT
    );

endinterface

// File: rtl/pulse_sched_rr_arb.sv
// Combinational round-robin search: first asserted request at or above ptr, with wrap.
module rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler driving one shared timed pulse followed by a fixed cooldown.
module pulse_sched
    import pulse_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = GAP_CYC_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    pulse_sched_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = 4;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic               arb_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_next;

    rr_arb #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (bus.REQ_IN),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Pointer moves to the slot just past the winner so it gets lowest priority next time.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) win_idx = PTR_W'(i);
        end
        ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (arb_valid) begin
                    state_d = PULSE;
                    gnt_d   = arb_gnt;
                    ptr_d   = ptr_next;
                    cnt_d   = (bus.LEN_IN == '0) ? '0 : bus.LEN_IN - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYC - 1);
                    gnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        // Registered outputs are derived from the next state so they line up with it.
        y_d    = (state_d == PULSE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Y_OUT    = y_q;
    assign bus.GNT_OUT  = gnt_q;
    assign bus.BUSY_OUT = busy_q;
    assign bus.DONE_OUT = done_q;

endmodule
